// File: rtl/uart_tx_unit.sv
// UART transmitter: accepts a byte on a Send/Busy handshake and shifts out an 11-bit frame
// (start, 8 data bits LSB first, parity slot, stop) at a selectable baud rate.
module uart_tx_unit #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Send,
  input  logic [7:0] Data,
  input  logic [1:0] ParityType,
  input  logic [1:0] BaudRate,
  output logic       DataTx,
  output logic       Busy,
  output logic       DoneFlag
);

  localparam logic [15:0] Div2400  = 16'(CLK_FREQ / 2400);
  localparam logic [15:0] Div4800  = 16'(CLK_FREQ / 4800);
  localparam logic [15:0] Div9600  = 16'(CLK_FREQ / 9600);
  localparam logic [15:0] Div19200 = 16'(CLK_FREQ / 19200);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} txStateT;

  txStateT     stateQ, stateD;
  logic [15:0] baudCntQ, baudCntD;
  logic [15:0] divQ, divD;
  logic [2:0]  bitIdxQ, bitIdxD;
  logic [7:0]  dataQ, dataD;
  logic [1:0]  parityQ, parityD;
  logic        txQ, txD;
  logic        busyQ, busyD;
  logic        doneQ, doneD;

  logic [15:0] divSel;
  logic        bitEnd;
  logic        parityBit;
  logic [2:0]  nextIdx;

  always_comb begin
    unique case (BaudRate)
      2'b00:   divSel = Div2400;
      2'b01:   divSel = Div4800;
      2'b10:   divSel = Div9600;
      default: divSel = Div19200;
    endcase
  end

  // The parity slot is always sent so the frame stays 11 bits long.
  always_comb begin
    unique case (parityQ)
      2'b01:   parityBit = ~(^dataQ);
      2'b10:   parityBit = ^dataQ;
      default: parityBit = 1'b1;
    endcase
  end

  assign bitEnd  = (baudCntQ == divQ - 16'd1);
  assign nextIdx = bitIdxQ + 3'd1;

  always_comb begin
    stateD   = stateQ;
    baudCntD = baudCntQ;
    divD     = divQ;
    bitIdxD  = bitIdxQ;
    dataD    = dataQ;
    parityD  = parityQ;
    txD      = txQ;
    busyD    = busyQ;
    doneD    = 1'b0;

    if (stateQ != StIdle) begin
      baudCntD = bitEnd ? 16'd0 : baudCntQ + 16'd1;
    end

    unique case (stateQ)
      StIdle: begin
        txD   = 1'b1;
        busyD = 1'b0;
        if (Send) begin
          dataD    = Data;
          parityD  = ParityType;
          divD     = divSel;
          baudCntD = 16'd0;
          bitIdxD  = 3'd0;
          txD      = 1'b0;
          busyD    = 1'b1;
          stateD   = StStart;
        end
      end
      StStart: begin
        if (bitEnd) begin
          txD     = dataQ[0];
          bitIdxD = 3'd0;
          stateD  = StData;
        end
      end
      StData: begin
        if (bitEnd) begin
          bitIdxD = nextIdx;
          if (bitIdxQ == 3'd7) begin
            txD    = parityBit;
            stateD = StParity;
          end else begin
            txD = dataQ[nextIdx];
          end
        end
      end
      StParity: begin
        if (bitEnd) begin
          txD    = 1'b1;
          stateD = StStop;
        end
      end
      StStop: begin
        if (bitEnd) begin
          txD    = 1'b1;
          busyD  = 1'b0;
          doneD  = 1'b1;
          stateD = StIdle;
        end
      end
      default: begin
        txD    = 1'b1;
        busyD  = 1'b0;
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateQ   <= StIdle;
      baudCntQ <= 16'd0;
      divQ     <= 16'd0;
      bitIdxQ  <= 3'd0;
      dataQ    <= 8'd0;
      parityQ  <= 2'd0;
      txQ      <= 1'b1;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      baudCntQ <= baudCntD;
      divQ     <= divD;
      bitIdxQ  <= bitIdxD;
      dataQ    <= dataD;
      parityQ  <= parityD;
      txQ      <= txD;
      busyQ    <= busyD;
      doneQ    <= doneD;
    end
  end

  assign DataTx   = txQ;
  assign Busy     = busyQ;
  assign DoneFlag = doneQ;

endmodule
